// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Converts RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) from the
// core's memory stage into whole-word accesses on a word-addressed data
// memory.
// - Loads: select the byte lane(s), then sign- or zero-extend the result.
// - Sub-word stores: read-modify-write, because the memory only takes full
//   words.
// - Misaligned accesses and unsupported funct3 codes end with an error and
//   never touch memory.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to also reject any access
// whose word address + 3 reaches MEM_BYTES.
//
// Parameters:
//   MEM_BYTES   data memory size in bytes (bounds check only)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   cpu_req     request strobe, sampled only in IDLE
//   cpu_we      1 = store, 0 = load
//   cpu_funct3  RV32I size/sign code
//   cpu_addr    byte address
//   cpu_wdata   store data (low byte/half used for SB/SH)
//   cpu_rdata   extended load result, held until the next successful load
//   cpu_done    one-cycle completion pulse
//   cpu_err     error flag, valid with cpu_done
//   busy        high whenever the unit is not IDLE
//   mem_addr    word-aligned memory address
//   mem_wdata   word to write
//   mem_we      word write enable
//   mem_rdata   combinational read data for mem_addr
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;

    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    // Only the low half of the store data is needed after acceptance:
    // a SW loads the merge register directly in IDLE.
    logic [15:0] wdata_reg;
    logic [31:0] merge_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    // ------------------------------------------------------------------
    // Legality of the incoming request
    // ------------------------------------------------------------------
    logic legal_code;
    logic misaligned;
    logic out_of_range;
    logic illegal;

    always_comb begin
        legal_code = 1'b0;
        if (cpu_we) begin
            legal_code = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) ||
                         (cpu_funct3 == 3'b010);
        end else begin
            legal_code = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) ||
                         (cpu_funct3 == 3'b010) || (cpu_funct3 == 3'b100) ||
                         (cpu_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the size for every legal code, so it is enough to
    // test alignment here; illegal codes are rejected anyway.
    assign misaligned = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                        ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
    // 33-bit sum so that addresses near 2^32 cannot wrap past the check.
    assign out_of_range = ({1'b0, cpu_addr[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES);
`else
    assign out_of_range = 1'b0;
`endif

    assign illegal = !legal_code || misaligned || out_of_range;

    // ------------------------------------------------------------------
    // Load extraction and store merge
    // ------------------------------------------------------------------
    logic [7:0]  rd_lane [4];
    logic [31:0] merged_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic lane_hit;

            assign rd_lane[gi] = mem_rdata[8*gi +: 8];

            // SH replaces the half picked by addr[1]; SB replaces one byte.
            assign lane_hit = funct3_reg[0] ? (addr_reg[1] == LANE[1])
                                            : (addr_reg[1:0] == LANE);

            assign merged_word[8*gi +: 8] =
                !lane_hit     ? rd_lane[gi] :
                funct3_reg[0] ? wdata_reg[8*(gi%2) +: 8] :
                                wdata_reg[7:0];
        end
    endgenerate

    assign ld_byte = rd_lane[addr_reg[1:0]];
    assign ld_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // funct3[2] set means unsigned (LBU/LHU).
    always_comb begin
        ld_ext = mem_rdata;
        case (funct3_reg[1:0])
            2'b00:   ld_ext = {{24{ld_byte[7] & ~funct3_reg[2]}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~funct3_reg[2]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cpu_req) begin
                    if (illegal) begin
                        state_next = S_DONE;
                    end else if (!cpu_we) begin
                        state_next = S_LOAD;
                    end else if (cpu_funct3[1:0] == 2'b10) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_RMW_READ;
                    end
                end
            end
            S_LOAD:     state_next = S_DONE;
            S_RMW_READ: state_next = S_WRITE;
            S_WRITE:    state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_reg <= 3'b000;
            addr_reg   <= 32'h0;
            wdata_reg  <= 16'h0;
            merge_reg  <= 32'h0;
            err_reg    <= 1'b0;
            rdata_reg  <= 32'h0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cpu_req) begin
                        funct3_reg <= cpu_funct3;
                        addr_reg   <= cpu_addr;
                        wdata_reg  <= cpu_wdata[15:0];
                        err_reg    <= illegal;
                        if (!illegal && cpu_we && (cpu_funct3[1:0] == 2'b10)) begin
                            merge_reg <= cpu_wdata;
                        end
                    end
                end
                S_LOAD:     rdata_reg <= ld_ext;
                S_RMW_READ: merge_reg <= merged_word;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // mem_addr follows the latched address, which only changes when a
    // request is accepted, so it naturally holds its value in IDLE.
    assign mem_addr  = {addr_reg[31:2], 2'b00};
    assign mem_wdata = merge_reg;
    // Gating with rst drops the write in the very cycle reset arrives.
    assign mem_we    = (state_reg == S_WRITE) && !rst;
    assign cpu_done  = (state_reg == S_DONE);
    assign cpu_err   = (state_reg == S_DONE) && err_reg;
    assign busy      = (state_reg != S_IDLE);
    assign cpu_rdata = rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// accesses against a byte-array reference model, and hand-written reset /
// busy sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_funct3 = 3'b000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Word memory (64 x 32 = 256 bytes), loaded from init_img at start.
    logic [31:0] mem [0:63];
    logic [31:0] init_img [0:63];
    logic        mem_load = 1'b1;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int w = 0; w < 64; w++) mem[w] <= init_img[w];
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    // Reference model state: plain byte array plus last load result.
    logic [7:0]  refb [0:255];
    logic [31:0] last_rdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // Reference: derived from the RV32I rules using byte arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] e_rd,
                         output logic e_err, output int e_lat, output int e_wes);
        int  nbytes;
        bit  ok;
        longint val;
        int  base;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if ((addr % nbytes) != 0) ok = 0;
`ifdef LSU_BOUNDS_CHECK_EN
        if ((longint'(addr) / 4) * 4 + 3 >= 256) ok = 0;
`endif
        e_err = !ok;
        e_wes = 0;
        if (!ok) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2;
            base  = int'(addr[7:0]);
            val   = 0;
            for (int i = 0; i < nbytes; i++) val += longint'(refb[base + i]) << (8 * i);
            if (f3[2] == 1'b0 && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
                val -= (longint'(1) << (8 * nbytes));
            last_rdata = val[31:0];
        end else begin
            e_lat = (nbytes == 4) ? 2 : 3;
            e_wes = 1;
            base  = int'(addr[7:0]);
            for (int i = 0; i < nbytes; i++) refb[base + i] = wd[8*i +: 8];
        end
        e_rd = last_rdata;
    endtask

    // Issues one request and watches it to completion (bounded).
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic er, output int lat, output int wes);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 0; wes = 0; rd = 32'h0; er = 1'b0;
        for (int k = 0; k < 10; k++) begin
            lat++;
            if (mem_we) wes++;
            if (cpu_done) begin
                rd = cpu_rdata;
                er = cpu_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (!cpu_done) lat = 99;
    endtask

    task automatic run_model_check(input string tag, input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd, e_rd;
        logic er, e_err;
        int lat, wes, e_lat, e_wes;
        do_access(we, f3, addr, wd, rd, er, lat, wes);
        model(we, f3, addr, wd, e_rd, e_err, e_lat, e_wes);
        $display("%s we=%0d f3=%0d addr=%08h wd=%08h -> rd=%08h err=%0d lat=%0d wes=%0d",
                 tag, we, f3, addr, wd, rd, er, lat, wes);
        chk({tag, " rdata"}, rd, e_rd);
        chk({tag, " err"}, 32'(er), 32'(e_err));
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " mem_we pulses"}, wes, e_wes);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wes;
    } vec_t;

    vec_t tbl [0:18];

    initial begin
        logic [31:0] rd, e_rd;
        logic er, e_err;
        int lat, wes, e_lat, e_wes, dones;
        logic [31:0] w;

        // Memory image and mirrored reference bytes.
        for (int i = 0; i < 64; i++) begin
            w = (i == 4) ? 32'h8899AABB : $urandom;
            init_img[i] = w;
            for (int b = 0; b < 4; b++) refb[4*i + b] = w[8*b +: 8];
        end
        last_rdata = 32'h0;

        tbl[0]  = '{1'b0, 3'd0, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
        tbl[1]  = '{1'b0, 3'd4, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 0};
        tbl[2]  = '{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 2, 0};
        tbl[3]  = '{1'b0, 3'd5, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 0};
        tbl[4]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 0};
        tbl[5]  = '{1'b1, 3'd0, 32'h13, 32'h12345655, 32'h8899AABB, 1'b0, 3, 1};
        tbl[6]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h5599AABB, 1'b0, 2, 0};
        tbl[7]  = '{1'b1, 3'd2, 32'h10, 32'h8899AABB, 32'h5599AABB, 1'b0, 2, 1};
        tbl[8]  = '{1'b1, 3'd1, 32'h10, 32'hDEAD1234, 32'h5599AABB, 1'b0, 3, 1};
        tbl[9]  = '{1'b1, 3'd2, 32'h14, 32'hCAFEF00D, 32'h5599AABB, 1'b0, 2, 1};
        tbl[10] = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h88991234, 1'b0, 2, 0};
        tbl[11] = '{1'b0, 3'd2, 32'h14, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0};
        tbl[12] = '{1'b0, 3'd2, 32'h22, 32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        tbl[13] = '{1'b1, 3'd1, 32'h21, 32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        tbl[14] = '{1'b0, 3'd3, 32'h10, 32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        tbl[15] = '{1'b1, 3'd4, 32'h10, 32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        tbl[16] = '{1'b0, 3'd1, 32'h11, 32'h0,        32'hCAFEF00D, 1'b1, 1, 0};
        tbl[17] = '{1'b0, 3'd0, 32'h17, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 0};
        tbl[18] = '{1'b0, 3'd5, 32'h16, 32'h0,        32'h0000CAFE, 1'b0, 2, 0};

        // Reset and check reset values.
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset cpu_done", 32'(cpu_done), 32'h0);
        chk("reset cpu_err", 32'(cpu_err), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset mem_we", 32'(mem_we), 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            do_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er, lat, wes);
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, e_rd, e_err, e_lat, e_wes);
            $display("vec %0d we=%0d f3=%0d addr=%08h -> rd=%08h err=%0d lat=%0d wes=%0d",
                     i, tbl[i].we, tbl[i].f3, tbl[i].addr, rd, er, lat, wes);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].err));
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d mem_we pulses", i), wes, tbl[i].wes);
        end
        @(negedge clk);
        chk("word 0x10 after SH", mem[4], 32'h88991234);
        chk("word 0x14 after SW", mem[5], 32'hCAFEF00D);

        // rst and cpu_req together: request dropped.
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h10;
        @(posedge clk); #1;
        chk("rst+req busy", 32'(busy), 32'h0);
        rst = 1'b0; cpu_req = 1'b0;
        last_rdata = 32'h0;
        chk("rst+req rdata cleared", cpu_rdata, 32'h0);

        // Reset during the WRITE cycle of an SB.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'd0; cpu_addr = 32'h21; cpu_wdata = 32'h77;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rmw reaches write", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        chk("write suppressed by rst", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("busy after abort", 32'(busy), 32'h0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            if (cpu_done) dones++;
            @(posedge clk); #1;
        end
        chk("no done after abort", dones, 0);
        chk("aborted word unchanged", mem[8],
            {refb[35], refb[34], refb[33], refb[32]});

        // cpu_req held while busy: only one accepted access.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h14;
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (cpu_done) dones++;
        end
        cpu_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (cpu_done) dones++;
        end
        chk("one done per accepted request", dones, 1);
        model(1'b0, 3'd2, 32'h14, 32'h0, e_rd, e_err, e_lat, e_wes);
        chk("held-req load rdata", cpu_rdata, e_rd);

`ifdef LSU_BOUNDS_CHECK_EN
        run_model_check("bounds", 1'b0, 3'd2, 32'hFC, 32'h0);
        run_model_check("bounds", 1'b0, 3'd2, 32'h100, 32'h0);
`endif

        // Random accesses against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            a = 32'($urandom_range(0, 255));
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'd1) a[0] = 1'b0;
                if (f[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            run_model_check($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), f, a, $urandom);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("final word %0d", i), mem[i],
                {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
